// File: rtl/aes_tcdm_responder_pkg.sv
// Shared types and constants for the TCDM responder memory model.
// Contents:
//   tcdm_resp_t      - per-port response register (read data + valid pulse)
//   DEADBEEF_PATTERN - read data returned for out-of-range accesses
//   LFSR_TAP_MASK    - Fibonacci feedback taps 16,14,13,11 (right-shifting form)
//   lfsr_next()      - one step of the stall LFSR
package aes_tcdm_responder_pkg;

  typedef struct packed {
    logic [31:0] r_data;
    logic        r_valid;
  } tcdm_resp_t;

  localparam logic [31:0] DEADBEEF_PATTERN = 32'hDEAD_BEEF;

  // Right-shift formulation: taps 16,14,13,11 map to state bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

endpackage

// File: rtl/aes_tcdm_responder_arbiter.sv
// Round-robin arbiter for one memory bank.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   req_i[MP]    - in-range requests targeting this bank
//   commit_i     - the winner is actually granted this cycle (no stall/reset)
//   win_o[MP]    - one-hot winner: first requester at or after the pointer
module tcdm_rr_arbiter #(
  parameter int unsigned MP = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [MP-1:0] req_i,
  input  logic          commit_i,
  output logic [MP-1:0] win_o
);

  localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [MP-1:0] mask;
  logic [MP-1:0] masked;
  logic [MP-1:0] pick;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MP; i++) begin
      mask[i] = (i >= int'(ptr_q));
    end
    masked = req_i & mask;
    // No requester at/after the pointer: wrap around to the lowest index.
    pick   = (|masked) ? masked : req_i;
    win_o  = pick & (~pick + MP'(1));
    ptr_d  = ptr_q;
    for (int i = 0; i < MP; i++) begin
      if (commit_i && win_o[i]) begin
        ptr_d = (i == MP - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aes_tcdm_responder.sv
// TCDM slave memory model serving MP request ports from a word-interleaved,
// banked memory. One grant per bank per cycle (round-robin), optional
// LFSR-driven grant stalls, fixed one-cycle response latency.
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   tcdm_req_i[p]       - request
//   tcdm_gnt_o[p]       - combinational grant in the request cycle
//   tcdm_add_i[p]       - byte address (bits 1:0 ignored)
//   tcdm_wen_i[p]       - 1 = read, 0 = write
//   tcdm_be_i[p]        - write byte enables
//   tcdm_data_i[p]      - write data
//   tcdm_r_data_o[p]    - response data (held when no response)
//   tcdm_r_valid_o[p]   - one-cycle response pulse, one cycle after gnt
//   err_cnt_o           - saturating count of granted out-of-range accesses
//   busy_o              - any r_valid asserted this cycle
module aes_tcdm_responder
  import aes_tcdm_responder_pkg::*;
#(
  parameter int unsigned MP         = 2,
  parameter int unsigned N_BANKS    = 4,
  parameter int unsigned BANK_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  output logic [15:0]          err_cnt_o,
  output logic                 busy_o
);

  localparam int unsigned BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned RW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(4 * N_BANKS * BANK_WORDS);

  // Address decode
  logic [MP-1:0][31:0]   offset;
  logic [MP-1:0][31:0]   word;
  logic [MP-1:0]         in_range;
  logic [MP-1:0][BW-1:0] bank;
  logic [MP-1:0][RW-1:0] row;

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      offset[p]   = tcdm_add_i[p] - BASE_ADDR;
      word[p]     = offset[p] >> 2;
      // The first term rejects addresses below the base whose offset wrapped.
      in_range[p] = (tcdm_add_i[p] >= BASE_ADDR) && ({1'b0, offset[p]} < MEM_BYTES);
      bank[p]     = BW'(word[p] % N_BANKS);
      row[p]      = RW'(word[p] / N_BANKS);
    end
  end

  // Stall LFSR
  logic [15:0] lfsr_q, lfsr_d;
  logic        stall;
  logic        grant_en;

  always_comb begin
    lfsr_d   = STALL_EN ? lfsr_next(lfsr_q) : lfsr_q;
    stall    = STALL_EN && (lfsr_q[1:0] == 2'b00);
    grant_en = ~stall & ~rst_i;
  end

  // Per-bank arbitration; out-of-range requests bypass the banks entirely.
  logic [N_BANKS-1:0][MP-1:0] bank_req;
  logic [N_BANKS-1:0][MP-1:0] bank_win;
  logic [MP-1:0]              win;
  logic [MP-1:0]              gnt;

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      for (int p = 0; p < MP; p++) begin
        bank_req[b][p] = tcdm_req_i[p] & in_range[p] & (bank[p] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank_arb
    tcdm_rr_arbiter #(
      .MP (MP)
    ) u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (bank_req[b]),
      .commit_i (grant_en),
      .win_o    (bank_win[b])
    );
  end

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      win[p] = ~in_range[p];
      for (int b = 0; b < N_BANKS; b++) begin
        if ((bank[p] == BW'(b)) && bank_win[b][p]) begin
          win[p] = 1'b1;
        end
      end
    end
    gnt        = tcdm_req_i & win & {MP{grant_en}};
    tcdm_gnt_o = gnt;
  end

  // Memory (never reset)
  logic [31:0] mem_q [N_BANKS][BANK_WORDS];
  logic [MP-1:0][31:0] rd_word;

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      rd_word[p] = '0;
      for (int b = 0; b < N_BANKS; b++) begin
        if (bank[p] == BW'(b)) begin
          rd_word[p] = mem_q[b][row[p]];
        end
      end
    end
  end

  // At most one port wins a bank per cycle, so port writes never collide.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (gnt[p] && !tcdm_wen_i[p] && in_range[p] && (bank[p] == BW'(b))) begin
          for (int i = 0; i < 4; i++) begin
            if (tcdm_be_i[p][i]) begin
              mem_q[b][row[p]][8*i +: 8] <= tcdm_data_i[p][8*i +: 8];
            end
          end
        end
      end
    end
  end

  // Responses and error counter
  tcdm_resp_t  resp_q [MP];
  tcdm_resp_t  resp_d [MP];
  logic [31:0] err_sum;
  logic [15:0] err_q, err_d;

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      resp_d[p].r_valid = gnt[p];
      resp_d[p].r_data  = resp_q[p].r_data;
      if (gnt[p]) begin
        if (!tcdm_wen_i[p]) begin
          resp_d[p].r_data = '0;
        end else if (in_range[p]) begin
          resp_d[p].r_data = rd_word[p];
        end else begin
          resp_d[p].r_data = DEADBEEF_PATTERN;
        end
      end
    end
    err_sum = {16'h0, err_q};
    for (int p = 0; p < MP; p++) begin
      if (gnt[p] && !in_range[p]) begin
        err_sum = err_sum + 32'd1;
      end
    end
    err_d = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < MP; p++) begin
        resp_q[p] <= '0;
      end
      err_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      for (int p = 0; p < MP; p++) begin
        resp_q[p] <= resp_d[p];
      end
      err_q  <= err_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      tcdm_r_data_o[p]  = resp_q[p].r_data;
      tcdm_r_valid_o[p] = resp_q[p].r_valid;
    end
    err_cnt_o = err_q;
    busy_o    = |tcdm_r_valid_o;
  end

endmodule
